// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS control path:
// opcodes, FSM state codes, ALUOp/ALUSrcB/PCSource encodings, control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_IEXEC    = 4'd9;
    localparam logic [3:0] S_IWB      = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_MEM,
        CLS_BEQ,
        CLS_J,
        CLS_IMM,
        CLS_BAD
    } op_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       zero_ext;
        logic       funct_sel;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal;
        logic       instr_done;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [5:0] op);
        op_class_t c;
        case (op)
            OP_RTYPE: c = CLS_R;
            OP_LW,
            OP_SW:    c = CLS_MEM;
            OP_BEQ:   c = CLS_BEQ;
            OP_J:     c = CLS_J;
            OP_ADDI,
            OP_ANDI,
            OP_ORI,
            OP_XORI,
            OP_LUI:   c = CLS_IMM;
            default:  c = CLS_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_word_decode.sv
// Combinational control word: state + Opcode + MemReady -> all datapath
// controls. Ports: state, opcode, mem_ready in; cw (ctrl_t) out.
module control_word_decode
    import mips_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                // IR and PC update only when the fetch read completes
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            S_DECODE: begin
                cw.alu_src_b = SRCB_IMMSH;
                cw.alu_op    = ALU_ADD;
                if (op_class(opcode) == CLS_BAD) begin
                    cw.illegal    = 1'b1;
                    cw.instr_done = 1'b1;
                end
            end
            S_MEMADR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                cw.mem_read = 1'b1;
                cw.iord     = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                cw.mem_write  = 1'b1;
                cw.iord       = 1'b1;
                cw.instr_done = mem_ready;
            end
            S_EXECUTE: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALU_RTYPE;
            end
            S_ALUWB: begin
                cw.reg_dst    = 1'b1;
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_op        = ALU_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = PCSRC_ALUOUT;
                cw.instr_done    = 1'b1;
            end
            S_IEXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_IMM;
                cw.funct_sel = 1'b1;
                // logical immediates zero-extend; addi/lui sign-extend
                cw.zero_ext  = (opcode == OP_ANDI) ||
                               (opcode == OP_ORI)  ||
                               (opcode == OP_XORI);
            end
            S_IWB: begin
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_JUMP: begin
                cw.pc_write   = 1'b1;
                cw.pc_source  = PCSRC_JUMP;
                cw.instr_done = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS core: state register and
// next-state logic; control outputs come from control_word_decode.
module multicycle_main_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic [1:0] ALUOp,
    output logic       FunctSel,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ZeroExt,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic       InstrDone,
    output logic [3:0] State
);

    logic [3:0] state;
    logic [3:0] nxt;
    ctrl_t      cw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_FETCH:    nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_class(Opcode))
                    CLS_MEM: nxt = S_MEMADR;
                    CLS_R:   nxt = S_EXECUTE;
                    CLS_BEQ: nxt = S_BRANCH;
                    CLS_J:   nxt = S_JUMP;
                    CLS_IMM: nxt = S_IEXEC;
                    default: nxt = S_FETCH;
                endcase
            end
            // only lw/sw reach MEMADR
            S_MEMADR:   nxt = (Opcode == OP_SW) ? S_MEMWRITE
                                                : S_MEMREAD;
            S_MEMREAD:  nxt = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: nxt = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  nxt = S_ALUWB;
            S_IEXEC:    nxt = S_IWB;
            default:    nxt = S_FETCH;
        endcase
    end

    control_word_decode u_dec (
        .state     (state),
        .opcode    (Opcode),
        .mem_ready (MemReady),
        .cw        (cw)
    );

    assign ALUOp       = cw.alu_op;
    assign FunctSel    = cw.funct_sel;
    assign PCWrite     = cw.pc_write;
    assign PCWriteCond = cw.pc_write_cond;
    assign IorD        = cw.iord;
    assign MemRead     = cw.mem_read;
    assign MemWrite    = cw.mem_write;
    assign IRWrite     = cw.ir_write;
    assign MemtoReg    = cw.mem_to_reg;
    assign RegDst      = cw.reg_dst;
    assign RegWrite    = cw.reg_write;
    assign ALUSrcA     = cw.alu_src_a;
    assign ZeroExt     = cw.zero_ext;
    assign ALUSrcB     = cw.alu_src_b;
    assign PCSource    = cw.pc_source;
    assign Illegal     = cw.illegal;
    assign InstrDone   = cw.instr_done;
    assign State       = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed instruction table, reset
// abort sequence, and random instruction stream against a phase model.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic [1:0] ALUOp;
    logic       FunctSel, PCWrite, PCWriteCond, IorD, MemRead;
    logic       MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
    logic       ALUSrcA, ZeroExt, Illegal, InstrDone;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_main_control dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .ALUOp       (ALUOp),
        .FunctSel    (FunctSel),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ZeroExt     (ZeroExt),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .Illegal     (Illegal),
        .InstrDone   (InstrDone),
        .State       (State)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] aluop;
        logic       fs, pcw, pcwc, iord, mrd, mwr, irw;
        logic       m2r, rdst, rw, srca, zext;
        logic [1:0] srcb, pcsrc;
        logic       ill, done;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        int         wf;
        int         wm;
        int         cycles;
        string      name;
    } vec_t;

    vec_t vecs[14];
    logic [5:0] legal[10];

    function automatic obs_t sample();
        obs_t o;
        o = '{st: State, aluop: ALUOp, fs: FunctSel, pcw: PCWrite,
              pcwc: PCWriteCond, iord: IorD, mrd: MemRead,
              mwr: MemWrite, irw: IRWrite, m2r: MemtoReg,
              rdst: RegDst, rw: RegWrite, srca: ALUSrcA,
              zext: ZeroExt, srcb: ALUSrcB, pcsrc: PCSource,
              ill: Illegal, done: InstrDone};
        return o;
    endfunction

    // 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 imm, 6 unsupported
    function automatic int kind(input logic [5:0] op);
        case (op)
            6'b000000: return 0;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100: return 3;
            6'b000010: return 4;
            6'b001000, 6'b001100, 6'b001101,
            6'b001110, 6'b001111: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int base_cycles(input int k);
        case (k)
            1: return 5;
            2, 0, 5: return 4;
            3, 4: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs for one cycle spent in the given phase
    function automatic obs_t model(input int ph, input logic [5:0] op,
                                   input logic mr);
        obs_t e;
        e = '0;
        e.st = 4'(ph);
        case (ph)
            0: begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
            1: begin
                e.srcb = 2'b11;
                e.ill = (kind(op) == 6);
                e.done = (kind(op) == 6);
            end
            2: begin e.srca = 1; e.srcb = 2'b10; end
            3: begin e.mrd = 1; e.iord = 1; end
            4: begin e.rw = 1; e.m2r = 1; e.done = 1; end
            5: begin e.mwr = 1; e.iord = 1; e.done = mr; end
            6: begin e.srca = 1; e.aluop = 2'b10; end
            7: begin e.rdst = 1; e.rw = 1; e.done = 1; end
            8: begin
                e.srca = 1; e.aluop = 2'b01; e.pcwc = 1;
                e.pcsrc = 2'b01; e.done = 1;
            end
            9: begin
                e.srca = 1; e.srcb = 2'b10; e.aluop = 2'b11; e.fs = 1;
                e.zext = (op == 6'b001100) || (op == 6'b001101) ||
                         (op == 6'b001110);
            end
            10: begin e.rw = 1; e.done = 1; end
            11: begin e.pcw = 1; e.pcsrc = 2'b10; e.done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
        end
    endtask

    // Entry: just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input int wf,
                             input int wm, input int exp_cyc,
                             input string nm);
        int ph[$];
        int cyc;
        case (kind(op))
            0: ph = '{0, 1, 6, 7};
            1: ph = '{0, 1, 2, 3, 4};
            2: ph = '{0, 1, 2, 5};
            3: ph = '{0, 1, 8};
            4: ph = '{0, 1, 11};
            5: ph = '{0, 1, 9, 10};
            default: ph = '{0, 1};
        endcase
        cyc = 0;
        foreach (ph[i]) begin
            int p;
            int reps;
            p = ph[i];
            reps = (p == 0) ? wf + 1 : (p == 3 || p == 5) ? wm + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                if (p == 0 || p == 3 || p == 5)
                    MemReady = (r == reps - 1);
                else
                    MemReady = 1'($urandom);
                // opcode only matters in DECODE/MEMADR/IEXEC
                if (p == 1 || p == 2 || p == 9) Opcode = op;
                else Opcode = 6'($urandom);
                #1;
                chk($sformatf("%s ph%0d c%0d", nm, p, cyc),
                    sample(), model(p, op, MemReady));
                cyc++;
                @(posedge clk);
                #1;
            end
        end
        chk_int({nm, " cycles"}, cyc, exp_cyc);
    endtask

    initial begin
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                  6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
        vecs[0]  = '{6'b100011, 0, 0, 5, "lw"};
        vecs[1]  = '{6'b101011, 0, 0, 4, "sw"};
        vecs[2]  = '{6'b101011, 0, 3, 7, "sw_wait3"};
        vecs[3]  = '{6'b000000, 0, 0, 4, "rtype"};
        vecs[4]  = '{6'b001000, 0, 0, 4, "addi"};
        vecs[5]  = '{6'b001100, 0, 0, 4, "andi"};
        vecs[6]  = '{6'b001101, 0, 0, 4, "ori"};
        vecs[7]  = '{6'b001110, 0, 0, 4, "xori"};
        vecs[8]  = '{6'b001111, 0, 0, 4, "lui"};
        vecs[9]  = '{6'b000100, 0, 0, 3, "beq"};
        vecs[10] = '{6'b000010, 0, 0, 3, "j"};
        vecs[11] = '{6'b111111, 0, 0, 2, "illegal"};
        vecs[12] = '{6'b100011, 2, 1, 8, "lw_wait"};
        vecs[13] = '{6'b010101, 1, 0, 3, "illegal_wait"};

        reset = 1'b1;
        MemReady = 1'b0;
        Opcode = 6'd0;
        #1;
        chk("reset_mr0", sample(), model(0, 6'd0, 1'b0));
        MemReady = 1'b1;
        #1;
        chk("reset_mr1", sample(), model(0, 6'd0, 1'b1));
        @(posedge clk);
        #1;
        chk("reset_hold", sample(), model(0, 6'd0, 1'b1));
        reset = 1'b0;

        foreach (vecs[i])
            run_instr(vecs[i].op, vecs[i].wf, vecs[i].wm,
                      vecs[i].cycles, vecs[i].name);

        // sw aborted by reset while waiting in MEMWRITE
        Opcode = 6'b101011;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        MemReady = 1'b0;
        #1;
        chk("abort_pre", sample(), model(5, 6'b101011, 1'b0));
        #1;
        reset = 1'b1;
        #1;
        chk("abort_now", sample(), model(0, 6'b101011, 1'b0));
        chk_int("abort_state", int'(State), 0);
        chk_int("abort_memwrite", int'(MemWrite), 0);
        @(posedge clk);
        #1;
        chk("abort_edge", sample(), model(0, 6'b101011, 1'b0));
        chk_int("abort_regwrite", int'(RegWrite), 0);
        reset = 1'b0;
        run_instr(6'b100011, 0, 0, 5, "post_abort_lw");

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            int wf;
            int wm;
            int k;
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = legal[$urandom_range(0, 9)];
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            k = kind(op);
            run_instr(op, wf, wm,
                      base_cycles(k) + wf + ((k == 1 || k == 2) ? wm : 0),
                      $sformatf("rnd%0d_op%b", n, op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control FSM for the multi-cycle MIPS core. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives every datapath enable and mux select, and produces the `ALUOp` code and Function-source select consumed directly by `ALUControl`. It sits between the instruction register (opcode source) and the datapath/ALU-control stage.

## Interface
Parameters:
- none; opcodes and state codes are fixed in the shared package.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; forces state FETCH immediately.
- `Opcode` in 6: IR[31:26]; stable from the end of FETCH until the next FETCH.
- `MemReady` in 1: memory completes the current read/write this cycle.
- `ALUOp` out 2: 00 add, 01 sub, 10 R-type, 11 immediate.
- `FunctSel` out 1: 1 selects `Opcode` onto ALUControl's Function input; 0 selects IR[5:0].
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`, `ZeroExt` out 1 each: datapath controls.
- `ALUSrcB` out 2: 00 reg B, 01 constant 4, 10 extended imm, 11 imm<<2.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `Illegal` out 1: one-cycle pulse in DECODE for an unsupported opcode.
- `InstrDone` out 1: high in the last cycle of each instruction.
- `State` out 4: current state, for debug.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
  - andi 001100
  - ori 001101
  - xori 001110
  - lui 001111
- State encoding and Moore outputs. Every output not listed is 0.
  - FETCH (0): MemRead=1, ALUSrcB=01. IRWrite=PCWrite=MemReady; these two are gated Mealy outputs. Hold in FETCH while MemReady=0; go to DECODE when MemReady=1.
  - DECODE (1): ALUSrcB=11, ALUOp=00. Branch on opcode:
    - lw/sw → MEMADR
    - R → EXECUTE
    - beq → BRANCH
    - j → JUMP
    - addi..lui → IEXEC
    - other → FETCH, with Illegal=1 and InstrDone=1.
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10. Next state MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD (3): MemRead=1, IorD=1. Hold until MemReady, then MEMWB.
  - MEMWB (4): RegWrite=1, MemtoReg=1, InstrDone=1. Next state FETCH.
  - MEMWRITE (5): MemWrite=1, IorD=1. Hold until MemReady; InstrDone=MemReady. Then FETCH.
  - EXECUTE (6): ALUSrcA=1, ALUOp=10. Next state ALUWB.
  - ALUWB (7): RegDst=1, RegWrite=1, InstrDone=1. Next state FETCH.
  - BRANCH (8): ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1. Next state FETCH.
  - IEXEC (9): ALUSrcA=1, ALUSrcB=10, ALUOp=11, FunctSel=1. ZeroExt=1 for andi/ori/xori. Next state IWB.
  - IWB (10): RegWrite=1, InstrDone=1. Next state FETCH.
  - JUMP (11): PCWrite=1, PCSource=10, InstrDone=1. Next state FETCH.
- Unused codes 12–15 go to FETCH on the next edge and drive all outputs to 0.
- lui shift amount (16) is supplied by the datapath, not by this block.

## Timing
- Reset: `State`=FETCH asynchronously. Outputs take FETCH values: MemRead=1, ALUSrcB=01, all else 0 (IRWrite/PCWrite follow MemReady). Release is synchronous to the next edge.
- Cycle counts with zero memory wait (MemReady=1 in every memory cycle):
  - lw 5
  - sw 4
  - R 4
  - immediate 4
  - beq 3
  - j 3
  - illegal 2
- Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly one cycle. No output changes while waiting, except the gated IRWrite/PCWrite.
- Reset asserted mid-instruction aborts it. No RegWrite/MemWrite is issued after assertion.
- Opcode changes outside DECODE/MEMADR/IEXEC are ignored.

## Structure
- Shared package `mips_pkg`:
  - opcode constants
  - 4-bit state codes
  - ALUOp codes (00/01/10/11)
  - ALUSrcB and PCSource encodings
- Sub-module `control_word_decode`: combinational state+Opcode+MemReady → control word. The FSM module holds only the state register and next-state logic.

## Test plan
- Reset mid-MEMWRITE → State=0 the same cycle, MemWrite=0, MemRead=1, ALUSrcB=01.
- lw (100011), MemReady=1 always → states 0,1,2,3,4, RegWrite=1 with MemtoReg=1 in cycle 5, InstrDone only in cycle 5.
- sw with MemReady low for 3 cycles in MEMWRITE → MemWrite=1, IorD=1 held 4 cycles, then FETCH.
- ori (001101) → IEXEC drives ALUOp=11, FunctSel=1, ZeroExt=1, ALUSrcB=10; IWB drives RegWrite=1, RegDst=0.
- beq → BRANCH drives ALUOp=01, PCWriteCond=1, PCSource=01. j → PCWrite=1, PCSource=10; both return to FETCH after 3 cycles.
- Opcode 111111 → Illegal=1 for one cycle in DECODE, no RegWrite/MemWrite, FETCH next.
